// File: rtl/clk_divider_bank.sv
// Bank of programmable clock dividers. Each channel has a registered divided clock, a rising-edge tick,
// and a double-buffered ratio that is handed over only at a period boundary, on sync, or while disabled.
module clk_divider_bank #(
  parameter int                    N_CH        = 2,
  parameter int                    DIV_W       = 8,
  parameter logic [N_CH*DIV_W-1:0] DEFAULT_DIV = {8'd4, 8'd2},
  localparam int                   CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_CH-1:0]  ch_en,
  input  logic             sync,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [DIV_W-1:0] cfg_div,
  output logic [N_CH-1:0]  clk_out,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  div_pending
);

  // Ratios below 2 cannot form a low and a high phase, so they are raised to 2.
  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] v);
    return (v < DIV_W'(2)) ? DIV_W'(2) : v;
  endfunction

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    localparam logic [DIV_W-1:0] DEF_DIV = clamp_div(DEFAULT_DIV[gi*DIV_W +: DIV_W]);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             pflag_q, pflag_d;
    logic [DIV_W-1:0] lo_len;
    logic             last, rise, wr, handover;

    always_comb begin
      lo_len   = (div_q >> 1) + DIV_W'(div_q[0]);
      last     = (cnt_q == div_q - DIV_W'(1));
      rise     = (cnt_q == lo_len - DIV_W'(1));
      wr       = cfg_we && (cfg_ch == CH_W'(gi));
      handover = !ch_en[gi] || sync || last;

      cnt_d  = cnt_q + DIV_W'(1);
      clk_d  = clk_q;
      tick_d = 1'b0;
      if (!ch_en[gi] || sync || last) begin
        cnt_d = '0;
        clk_d = 1'b0;
      end else if (rise) begin
        clk_d  = 1'b1;
        tick_d = 1'b1;
      end

      // A write landing on a hand-over edge stays pending; the older value is consumed first.
      div_d   = div_q;
      pend_d  = pend_q;
      pflag_d = pflag_q;
      if (handover && pflag_q) begin
        div_d   = pend_q;
        pflag_d = 1'b0;
      end
      if (wr) begin
        pend_d  = clamp_div(cfg_div);
        pflag_d = 1'b1;
      end
    end

    always_ff @(posedge CLK) begin
      if (RST) begin
        cnt_q   <= '0;
        div_q   <= DEF_DIV;
        pend_q  <= DEF_DIV;
        clk_q   <= 1'b0;
        tick_q  <= 1'b0;
        pflag_q <= 1'b0;
      end else begin
        cnt_q   <= cnt_d;
        div_q   <= div_d;
        pend_q  <= pend_d;
        clk_q   <= clk_d;
        tick_q  <= tick_d;
        pflag_q <= pflag_d;
      end
    end

    assign clk_out[gi]     = clk_q;
    assign tick[gi]        = tick_q;
    assign div_pending[gi] = pflag_q;
  end

endmodule

// File: tb/tb_clk_divider_bank.sv
// Directed bench for clk_divider_bank with three channels: ch0 default 4, ch1 default 2, ch2 default 1 (reads as 2).
// Vectors are {ch2,ch1,ch0}; each step advances one clock and checks clk_out, tick and div_pending.
module tb_clk_divider_bank;

  logic       CLK = 1'b0;
  logic       RST;
  logic [2:0] ch_en;
  logic       sync;
  logic       cfg_we;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_div;
  logic [2:0] clk_out;
  logic [2:0] tick;
  logic [2:0] div_pending;

  int n_assert = 0;
  int n_fail   = 0;

  clk_divider_bank #(
    .N_CH       (3),
    .DIV_W      (8),
    .DEFAULT_DIV({8'd1, 8'd2, 8'd4})
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .ch_en      (ch_en),
    .sync       (sync),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_div    (cfg_div),
    .clk_out    (clk_out),
    .tick       (tick),
    .div_pending(div_pending)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [2:0] ec, input logic [2:0] et, input logic [2:0] ep);
    n_assert++;
    assert (clk_out === ec) else begin
      n_fail++;
      $error("FAIL %s clk_out observed=%b expected=%b", tag, clk_out, ec);
    end
    n_assert++;
    assert (tick === et) else begin
      n_fail++;
      $error("FAIL %s tick observed=%b expected=%b", tag, tick, et);
    end
    n_assert++;
    assert (div_pending === ep) else begin
      n_fail++;
      $error("FAIL %s div_pending observed=%b expected=%b", tag, div_pending, ep);
    end
    $display("%s: clk_out=%b tick=%b div_pending=%b", tag, clk_out, tick, div_pending);
  endtask

  task automatic adv(input string tag, input logic [2:0] ec, input logic [2:0] et, input logic [2:0] ep);
    step();
    chk(tag, ec, et, ep);
  endtask

  // Default ratios: ch0 = 4 (low,low,high,high), ch1/ch2 = 2 (high on odd cycles).
  task automatic default_run(input string tag, input int ncyc);
    logic [2:0] ec, et;
    for (int k = 1; k <= ncyc; k++) begin
      ec = {k[0], k[0], ((k % 4) >= 2)};
      et = {k[0], k[0], ((k % 4) == 2)};
      adv($sformatf("%s_k%0d", tag, k), ec, et, 3'b000);
    end
  endtask

  task automatic write_cfg(input logic [1:0] ch, input logic [7:0] div);
    cfg_we  = 1'b1;
    cfg_ch  = ch;
    cfg_div = div;
  endtask

  initial begin
    RST = 1'b1; ch_en = 3'b111; sync = 1'b0;
    write_cfg(2'd0, 8'd9);                    // must be discarded under reset
    step();
    cfg_we = 1'b0;
    step();
    chk("reset", 3'b000, 3'b000, 3'b000);
    RST = 1'b0;

    default_run("t1", 12);

    // Mid-period ratio change on ch0: old 4-cycle period completes first.
    adv("t2_k13", 3'b110, 3'b110, 3'b000);
    write_cfg(2'd0, 8'd6);
    adv("t2_k14", 3'b001, 3'b001, 3'b001);
    cfg_we = 1'b0;
    adv("t2_k15", 3'b111, 3'b110, 3'b001);
    adv("t2_k16", 3'b000, 3'b000, 3'b000);
    adv("t2_k17", 3'b110, 3'b110, 3'b000);
    adv("t2_k18", 3'b000, 3'b000, 3'b000);
    adv("t2_k19", 3'b111, 3'b111, 3'b000);
    adv("t2_k20", 3'b001, 3'b000, 3'b000);
    adv("t2_k21", 3'b111, 3'b110, 3'b000);
    adv("t2_k22", 3'b000, 3'b000, 3'b000);
    adv("t2_k23", 3'b110, 3'b110, 3'b000);

    // Clamp of 0 and 1 on ch1 (write on a boundary edge stays pending), then an out-of-range channel.
    write_cfg(2'd1, 8'd0);
    adv("t3_k24", 3'b000, 3'b000, 3'b010);
    cfg_we = 1'b0;
    adv("t3_k25", 3'b111, 3'b111, 3'b010);
    adv("t3_k26", 3'b001, 3'b000, 3'b000);
    write_cfg(2'd1, 8'd1);
    adv("t3_k27", 3'b111, 3'b110, 3'b010);
    cfg_we = 1'b0;
    adv("t3_k28", 3'b000, 3'b000, 3'b000);
    write_cfg(2'd3, 8'd9);
    adv("t3_k29", 3'b110, 3'b110, 3'b000);
    cfg_we = 1'b0;
    adv("t3_k30", 3'b000, 3'b000, 3'b000);
    adv("t3_k31", 3'b111, 3'b111, 3'b000);

    // Ratios ch0=5, ch1=3, then a sync pulse.
    write_cfg(2'd0, 8'd5);
    adv("t4_k32", 3'b001, 3'b000, 3'b001);
    write_cfg(2'd1, 8'd3);
    adv("t4_k33", 3'b111, 3'b110, 3'b011);
    cfg_we = 1'b0;
    adv("t4_k34", 3'b000, 3'b000, 3'b000);
    adv("t4_k35", 3'b100, 3'b100, 3'b000);
    adv("t4_k36", 3'b010, 3'b010, 3'b000);
    sync = 1'b1;
    adv("t4_k37", 3'b000, 3'b000, 3'b000);
    sync = 1'b0;
    adv("t4_k38", 3'b100, 3'b100, 3'b000);
    adv("t4_k39", 3'b010, 3'b010, 3'b000);
    adv("t4_k40", 3'b101, 3'b101, 3'b000);
    adv("t4_k41", 3'b001, 3'b000, 3'b000);
    adv("t4_k42", 3'b110, 3'b110, 3'b000);

    // Disable ch0 while high with ratio 4 pending, then re-enable.
    adv("t5_k43", 3'b000, 3'b000, 3'b000);
    write_cfg(2'd0, 8'd4);
    adv("t5_k44", 3'b100, 3'b100, 3'b001);
    cfg_we = 1'b0;
    adv("t5_k45", 3'b011, 3'b011, 3'b001);
    ch_en = 3'b110;
    adv("t5_k46", 3'b100, 3'b100, 3'b000);
    adv("t5_k47", 3'b000, 3'b000, 3'b000);
    adv("t5_k48", 3'b110, 3'b110, 3'b000);
    ch_en = 3'b111;
    adv("t5_k49", 3'b000, 3'b000, 3'b000);
    adv("t5_k50", 3'b101, 3'b101, 3'b000);
    adv("t5_k51", 3'b011, 3'b010, 3'b000);
    adv("t5_k52", 3'b100, 3'b100, 3'b000);

    // Reset mid-period with a write pending: defaults return, pending is dropped.
    write_cfg(2'd0, 8'd7);
    adv("t6_k53", 3'b000, 3'b000, 3'b001);
    cfg_we = 1'b0;
    RST    = 1'b1;
    adv("t6_reset", 3'b000, 3'b000, 3'b000);
    RST = 1'b0;
    default_run("t6", 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
